dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  MEM-stage data-memory initiator; the producer side of the MEM/WB pipeline register.
//  Takes the EX/MEM load/store, runs the dmem req/resp handshake, and formats store data/masks.
//  Sign/zero-extends load data and holds it stable as mem_data_out until the pipeline advances.
//  Drives mem_stall into the hazard logic so MEM/WB `load` stays low while an access is open.
// PARAMETERS
//  XLEN     32  data/address width (only 32 is supported)
//  MASK_W   4   byte-enable width, XLEN/8
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst           in   1      reset; synchronous, active-high
//  op_valid      in   1      EX/MEM holds a valid load or store this cycle
//  is_load       in   1      op is a load (exclusive with is_store)
//  is_store      in   1      op is a store
//  funct3        in   3      RV32I width/sign code (lb/lh/lw/lbu/lhu, sb/sh/sw)
//  addr          in   XLEN   byte address from ALU
//  store_data    in   XLEN   rs2 value
//  advance       in   1      global pipeline load this cycle (EX/MEM->MEM/WB transfer)
//  dmem_read     out  1      read request
//  dmem_write    out  1      write request
//  dmem_address  out  XLEN   word-aligned address, {addr[31:2],2'b00}
//  dmem_wmask    out  MASK_W byte enables for writes
//  dmem_wdata    out  XLEN   lane-shifted store data
//  dmem_resp     in   1      one-cycle completion pulse from memory
//  dmem_rdata    in   XLEN   read data, valid with dmem_resp
//  mem_data_out  out  XLEN   formatted load result to MEM/WB
//  mem_stall     out  1      hold pipeline; access not yet complete
//  mem_misalign  out  1      current op is misaligned; no request issued
// BEHAVIOUR
//  Reset: state=IDLE; data_q=0; all req outputs 0; mem_stall=0; mem_data_out=0; mem_misalign=0.
//  FSM states: IDLE, BUSY, DONE.
//  - IDLE, op_valid & aligned: assert req combinationally from inputs; capture addr/funct3/wdata.
//    dmem_resp same cycle -> capture data, go DONE; otherwise go BUSY.
//  - BUSY: drive req from captured regs (inputs ignored); hold until dmem_resp -> capture, DONE.
//  - DONE: no request; mem_stall=0; advance=1 -> IDLE; advance=0 -> stay DONE, data held.
//  - IDLE, op_valid=0: no req, no stall, stay IDLE.
//  mem_stall = op_valid & aligned & (state!=DONE); deasserted exactly one cycle after resp.
//  Minimum latency: resp in issue cycle -> 1 stall cycle; resp N cycles later -> N+1 stall cycles.
//  dmem_read and dmem_write are never both 1; request level is held constant until resp.
//  Misalignment (lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0):
//    no request; mem_misalign=1 (combinational); mem_stall=0; mem_data_out=0.
//  Store masks: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111.
//  Store data: byte/half replicated across lanes, then shifted by 8*addr[1:0].
//  Load format uses captured offset/funct3 on data_q:
//    lb/lbu: byte at 8*off, sign/zero-extend; lh/lhu: half at 8*off, sign/zero-extend; lw: as-is.
//  Stores: data_q unchanged; mem_data_out shows the last load value.
//  Illegal funct3 on a valid op: treated as misaligned (no req, flag set).
//  Stray dmem_resp in IDLE/DONE: ignored.
//  rst mid-access (BUSY): immediate return to IDLE next edge, requests dropped.
//    The memory side must tolerate an abandoned request.
// STRUCTURE
//  rv32i_types package: load_funct3_t/store_funct3_t enums (already present).
//  Add to rv32i_types: dmem_state_t {IDLE,BUSY,DONE}.
//  Sub-module dmem_format (combinational): store mask/wdata generation and load extension.
//  dmem_format is shared with any later cache-side formatting.
//  Top level holds FSM, capture registers, stall/misalign logic only.
// TESTING
//  1. lw addr=0x100, resp 3 cycles later, rdata=0xDEADBEEF
//     -> read held 3 cycles, stall 4 cycles, mem_data_out=0xDEADBEEF.
//  2. lb addr=0x103, rdata=0x80FF_0000 -> mem_data_out=0xFFFFFF80; lbu same -> 0x00000080.
//  3. sh addr=0x202, store_data=0x1234ABCD
//     -> wmask=4'b1100, wdata=0xABCDABCD, dmem_address=0x200, no read.
//  4. lw addr=0x101 -> no request, mem_misalign=1, mem_stall=0 that cycle.
//  5. Resp in DONE with advance=0 for 5 cycles
//     -> data stable, no new request; advance=1 -> IDLE.
//  6. rst asserted while BUSY -> next cycle all req outputs 0, stall 0, state IDLE.
//     A following lw completes normally.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I encodings and the MEM-stage data-memory FSM state.
package rv32i_types;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } dmem_state_t;

  // Legal width code with natural alignment; anything else is rejected as misaligned.
  function automatic logic access_ok(input logic       is_load,
                                     input logic       is_store,
                                     input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    if (is_load) begin
      case (funct3)
        LB, LBU: ok = 1'b1;
        LH, LHU: ok = ~offset[0];
        LW:      ok = (offset == 2'b00);
        default: ok = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        SB:      ok = 1'b1;
        SH:      ok = ~offset[0];
        SW:      ok = (offset == 2'b00);
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_format.sv
// Combinational store lane/mask generation and load extraction with sign/zero extension.
module dmem_format
  import rv32i_types::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MASK_W = XLEN / 8
) (
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_offset,
  input  logic [XLEN-1:0]   st_data,
  output logic [MASK_W-1:0] wmask,
  output logic [XLEN-1:0]   wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_offset,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   ld_data
);

  logic [XLEN-1:0] ld_shifted;

  // Replication already places the datum in every lane, so the lane shift is a rotate
  // that leaves the replicated word unchanged.
  always_comb begin
    wmask = '0;
    wdata = st_data;
    case (st_funct3)
      SB: begin
        wmask = MASK_W'(4'b0001) << st_offset;
        wdata = {4{st_data[7:0]}};
      end
      SH: begin
        wmask = MASK_W'(4'b0011) << st_offset;
        wdata = {2{st_data[15:0]}};
      end
      default: begin
        wmask = MASK_W'(4'b1111);
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_shifted = ld_raw >> {ld_offset, 3'b000};
    case (ld_funct3)
      LB:      ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LBU:     ld_data = {24'h0, ld_shifted[7:0]};
      LH:      ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LHU:     ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory initiator: req/resp FSM, capture registers, stall and misalign flags.
module dmem_access_unit
  import rv32i_types::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic              advance,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [XLEN-1:0]   dmem_address,
  output logic [MASK_W-1:0] dmem_wmask,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_resp,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic [XLEN-1:0]   mem_data_out,
  output logic              mem_stall,
  output logic              mem_misalign
);

  dmem_state_t     state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] sdata_q, sdata_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            is_load_q, is_load_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [2:0]      ld_funct3_q, ld_funct3_d;
  logic [1:0]      ld_off_q, ld_off_d;

  logic            op_ok, issue;
  logic            cur_load;
  logic [2:0]      cur_funct3;
  logic [XLEN-1:0] cur_addr, cur_sdata;
  logic [MASK_W-1:0] fmt_wmask;
  logic [XLEN-1:0] fmt_wdata, fmt_ld_data;

  assign op_ok = op_valid & access_ok(is_load, is_store, funct3, addr[1:0]);

  // Live inputs only matter on the issue cycle; afterwards the captured copy drives memory.
  assign cur_load   = (state_q == IDLE) ? is_load    : is_load_q;
  assign cur_funct3 = (state_q == IDLE) ? funct3     : funct3_q;
  assign cur_addr   = (state_q == IDLE) ? addr       : addr_q;
  assign cur_sdata  = (state_q == IDLE) ? store_data : sdata_q;

  dmem_format #(
    .XLEN  (XLEN),
    .MASK_W(MASK_W)
  ) u_format (
    .st_funct3(cur_funct3),
    .st_offset(cur_addr[1:0]),
    .st_data  (cur_sdata),
    .wmask    (fmt_wmask),
    .wdata    (fmt_wdata),
    .ld_funct3(ld_funct3_q),
    .ld_offset(ld_off_q),
    .ld_raw   (data_q),
    .ld_data  (fmt_ld_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    sdata_d     = sdata_q;
    funct3_d    = funct3_q;
    is_load_d   = is_load_q;
    data_d      = data_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    issue       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_ok) begin
          issue     = 1'b1;
          addr_d    = addr;
          sdata_d   = store_data;
          funct3_d  = funct3;
          is_load_d = is_load;
          state_d   = dmem_resp ? DONE : BUSY;
        end
      end
      BUSY: begin
        issue = 1'b1;
        if (dmem_resp) state_d = DONE;
      end
      DONE: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Stores leave data_q alone so mem_data_out keeps the last load result.
    if (issue && dmem_resp && cur_load) begin
      data_d      = dmem_rdata;
      ld_funct3_d = cur_funct3;
      ld_off_d    = cur_addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sdata_q     <= '0;
      funct3_q    <= '0;
      is_load_q   <= 1'b0;
      data_q      <= '0;
      ld_funct3_q <= LW;
      ld_off_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sdata_q     <= sdata_d;
      funct3_q    <= funct3_d;
      is_load_q   <= is_load_d;
      data_q      <= data_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
    end
  end

  always_comb begin
    dmem_read    = issue & cur_load;
    dmem_write   = issue & ~cur_load;
    dmem_address = {cur_addr[XLEN-1:2], 2'b00};
    dmem_wmask   = dmem_write ? fmt_wmask : '0;
    dmem_wdata   = dmem_write ? fmt_wdata : '0;
    mem_stall    = issue;
    mem_misalign = (state_q == IDLE) & op_valid & ~op_ok;
    mem_data_out = mem_misalign ? '0 : fmt_ld_data;
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed self-checking bench for dmem_access_unit.
module tb_dmem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid, is_load, is_store, advance;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        dmem_read, dmem_write, dmem_resp;
  logic [31:0] dmem_address, dmem_wdata, dmem_rdata, mem_data_out;
  logic [3:0]  dmem_wmask;
  logic        mem_stall, mem_misalign;

  int n_chk = 0;
  int n_bad = 0;
  int stalls, rwait;

  dmem_access_unit u_dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .is_load     (is_load),
    .is_store    (is_store),
    .funct3      (funct3),
    .addr        (addr),
    .store_data  (store_data),
    .advance     (advance),
    .dmem_read   (dmem_read),
    .dmem_write  (dmem_write),
    .dmem_address(dmem_address),
    .dmem_wmask  (dmem_wmask),
    .dmem_wdata  (dmem_wdata),
    .dmem_resp   (dmem_resp),
    .dmem_rdata  (dmem_rdata),
    .mem_data_out(mem_data_out),
    .mem_stall   (mem_stall),
    .mem_misalign(mem_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd);
    op_valid   = 1'b1;
    is_load    = ld;
    is_store   = ~ld;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  // Issue a load, respond lat cycles after issue, leave the DUT in DONE.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input int lat,
                          input logic [31:0] rd, output int n_stall, output int n_wait);
    n_stall = 0;
    n_wait  = 0;
    set_op(1'b1, f3, a, 32'h0);
    for (int c = 0; c <= lat; c++) begin
      dmem_resp  = (c == lat);
      dmem_rdata = (c == lat) ? rd : 32'h5555_5555;
      if (c > 0) addr = a + 32'h10;  // a held request must ignore live inputs
      @(negedge clk);
      if (mem_stall) n_stall++;
      if (dmem_read && !dmem_resp) n_wait++;
      check("req_addr", dmem_address, {a[31:2], 2'b00});
      next_cycle();
    end
    dmem_resp = 1'b0;
    addr      = a;
  endtask

  task automatic retire();
    advance = 1'b1;
    next_cycle();
    advance  = 1'b0;
    op_valid = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input int lat, input logic [31:0] rd, input logic [31:0] exp);
    run_load(f3, a, lat, rd, stalls, rwait);
    check({tag, "_stalls"}, stalls, lat + 1);
    @(negedge clk);
    check({tag, "_data"}, mem_data_out, exp);
    check({tag, "_stall_done"}, mem_stall, 1'b0);
    retire();
  endtask

  task automatic store_case(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [3:0] m, input logic [31:0] wd,
                            input logic [31:0] last_ld);
    set_op(1'b0, f3, a, sd);
    dmem_resp = 1'b1;
    @(negedge clk);
    check({tag, "_mask"}, dmem_wmask, m);
    check({tag, "_wdata"}, dmem_wdata, wd);
    check({tag, "_addr"}, dmem_address, {a[31:2], 2'b00});
    check({tag, "_write"}, dmem_write, 1'b1);
    check({tag, "_read"}, dmem_read, 1'b0);
    check({tag, "_stall"}, mem_stall, 1'b1);
    next_cycle();
    dmem_resp = 1'b0;
    @(negedge clk);
    check({tag, "_stall_done"}, mem_stall, 1'b0);
    check({tag, "_keep_ld"}, mem_data_out, last_ld);
    retire();
  endtask

  task automatic misalign_case(input string tag, input logic ld, input logic [2:0] f3,
                               input logic [31:0] a);
    set_op(ld, f3, a, 32'hFFFF_FFFF);
    @(negedge clk);
    check({tag, "_flag"}, mem_misalign, 1'b1);
    check({tag, "_stall"}, mem_stall, 1'b0);
    check({tag, "_req"}, {dmem_read, dmem_write}, 2'b00);
    check({tag, "_data"}, mem_data_out, 32'h0);
    next_cycle();
    op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; advance = 1'b0;
    funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
    dmem_resp = 1'b0; dmem_rdata = 32'h0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_req", {dmem_read, dmem_write}, 2'b00);
    check("rst_stall", mem_stall, 1'b0);
    check("rst_data", mem_data_out, 32'h0);
    check("rst_misalign", mem_misalign, 1'b0);
    rst = 1'b0;
    next_cycle();

    // lw with a 3-cycle response
    run_load(3'b010, 32'h100, 3, 32'hDEAD_BEEF, stalls, rwait);
    check("lw_stalls", stalls, 4);
    check("lw_read_wait", rwait, 3);
    @(negedge clk);
    check("lw_data", mem_data_out, 32'hDEAD_BEEF);
    check("lw_stall_done", mem_stall, 1'b0);
    retire();

    load_case("lb", 3'b000, 32'h103, 0, 32'h80FF_0000, 32'hFFFF_FF80);
    load_case("lbu", 3'b100, 32'h103, 0, 32'h80FF_0000, 32'h0000_0080);
    load_case("lh", 3'b001, 32'h102, 1, 32'h8001_0000, 32'hFFFF_8001);
    load_case("lhu", 3'b101, 32'h102, 0, 32'h8001_0000, 32'h0000_8001);

    store_case("sh", 3'b001, 32'h202, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD, 32'h0000_8001);
    store_case("sb", 3'b000, 32'h301, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5, 32'h0000_8001);
    store_case("sw", 3'b010, 32'h400, 32'h0BAD_F00D, 4'b1111, 32'h0BAD_F00D, 32'h0000_8001);

    misalign_case("mis_lw", 1'b1, 3'b010, 32'h101);
    misalign_case("mis_lh", 1'b1, 3'b001, 32'h103);
    misalign_case("mis_sw", 1'b0, 3'b010, 32'h402);
    misalign_case("bad_f3", 1'b1, 3'b011, 32'h100);
    @(negedge clk);
    check("mis_clear", mem_misalign, 1'b0);
    check("mis_keep_ld", mem_data_out, 32'h0000_8001);
    next_cycle();

    // DONE held with stray responses
    run_load(3'b010, 32'h104, 1, 32'h1122_3344, stalls, rwait);
    check("hold_stalls", stalls, 2);
    for (int i = 0; i < 5; i++) begin
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("hold_data", mem_data_out, 32'h1122_3344);
      check("hold_req", {dmem_read, dmem_write}, 2'b00);
      check("hold_stall", mem_stall, 1'b0);
      next_cycle();
    end
    dmem_resp = 1'b0;
    retire();
    @(negedge clk);
    check("idle_req", {dmem_read, dmem_write}, 2'b00);
    check("idle_stall", mem_stall, 1'b0);
    next_cycle();

    // reset while BUSY
    set_op(1'b1, 3'b010, 32'h108, 32'h0);
    next_cycle();
    @(negedge clk);
    check("busy_read", dmem_read, 1'b1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    check("rst_busy_req", {dmem_read, dmem_write}, 2'b00);
    check("rst_busy_stall", mem_stall, 1'b0);
    check("rst_busy_data", mem_data_out, 32'h0);
    next_cycle();
    load_case("post_rst", 3'b010, 32'h10C, 2, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
